kbd_matrix_mapper: RTL and testbench

- Parametrised PS/2-scancode to keyboard-matrix translator; the table-driven successor of the fixed 8x8 matrix decoder.
- Scancode-to-matrix mapping lives in a host-loadable RAM, so one block serves any matrix geometry and layout.
- Key events are buffered in a FIFO and applied to a COLS x ROWS key-state array.
- The CPU-side column scan reads active-low row bits; F11/F10 drive the reset/NMI hotkeys.

---
 rtl/kbd_matrix_mapper.sv | 193 +++++++++++++++++++
 tb/tb_kbd_matrix_mapper.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_matrix_mapper.sv
// Table-driven PS/2 scancode to keyboard-matrix translator.
// A host-loaded map RAM picks the matrix cell for each event. F11 and F10 drive the reset and NMI hotkeys.
module kbd_matrix_mapper #(
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int COLW       = 3,
  parameter int ROWW       = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_PULSE  = 16
) (
  input  logic                 i_clk_sys,
  input  logic                 i_reset,
  input  logic                 i_key_strobe,
  input  logic                 i_key_pressed,
  input  logic                 i_key_extended,
  input  logic [7:0]           i_key_code,
  input  logic                 i_map_we,
  input  logic [8:0]           i_map_addr,
  input  logic [COLW+ROWW:0]   i_map_data,
  input  logic                 i_clear_all,
  input  logic [COLW-1:0]      i_col,
  output logic [ROWS-1:0]      o_ROWbit,
  output logic                 o_swrst,
  output logic                 o_swnmi,
  output logic                 o_any_key,
  output logic                 o_ovf
);

  localparam int MW = 1 + COLW + ROWW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RST_PULSE + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_APPLY  = 2'd2;

  logic [9:0]                 r_fifoMem [FIFO_DEPTH];
  logic [AW:0]                r_wrPtr;
  logic [AW:0]                r_rdPtr;
  logic                       r_ovf;
  logic [1:0]                 r_state;
  logic [9:0]                 r_evt;
  logic [MW-1:0]              r_mapRam [512];
  logic [MW-1:0]              r_entry;
  logic [COLS-1:0][ROWS-1:0]  r_keys;
  logic                       r_swrstHeld;
  logic [CW-1:0]              r_swrstCnt;
  logic                       r_swnmi;
  logic [ROWS-1:0]            r_rowBit;
  logic                       r_anyKey;

  logic                       w_empty;
  logic                       w_full;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_entryValid;
  logic [COLW-1:0]            w_entryCol;
  logic [ROWW-1:0]            w_entryRow;
  logic                       w_entryInRange;
  logic                       w_isF11;
  logic                       w_isF10;
  logic [ROWS-1:0]            w_rowNext;

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop   = (r_state == ST_IDLE) && !w_empty;
  // A pop in the same cycle frees a slot, so a strobe on a full FIFO is still accepted then.
  assign w_push  = i_key_strobe && (!w_full || w_pop);

  always_ff @(posedge i_clk_sys) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr[AW-1:0]] <= {i_key_pressed, i_key_extended, i_key_code};
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + (AW+1)'(1);
      end
      if (i_key_strobe && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_evt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_evt   <= r_fifoMem[r_rdPtr[AW-1:0]];
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (!i_map_we) begin
            r_state <= ST_APPLY;
          end
        end
        ST_APPLY: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Single-port map RAM: a host write owns the port and defers the LOOKUP read by a cycle.
  always_ff @(posedge i_clk_sys) begin
    if (i_map_we) begin
      r_mapRam[i_map_addr] <= i_map_data;
    end else if (r_state == ST_LOOKUP) begin
      r_entry <= r_mapRam[r_evt[8:0]];
    end
  end

  assign w_entryValid   = r_entry[MW-1];
  assign w_entryCol     = r_entry[COLW+ROWW-1:ROWW];
  assign w_entryRow     = r_entry[ROWW-1:0];
  assign w_entryInRange = w_entryValid && (int'(w_entryCol) < COLS) && (int'(w_entryRow) < ROWS);
  assign w_isF11        = !r_evt[8] && (r_evt[7:0] == 8'h78);
  assign w_isF10        = !r_evt[8] && (r_evt[7:0] == 8'h09);

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_keys      <= '0;
      r_swrstHeld <= 1'b0;
      r_swrstCnt  <= '0;
      r_swnmi     <= 1'b0;
    end else begin
      if (r_swrstCnt != '0) begin
        r_swrstCnt <= r_swrstCnt - CW'(1);
      end
      if (i_clear_all) begin
        r_keys      <= '0;
        r_swrstHeld <= 1'b0;
        r_swnmi     <= 1'b0;
      end else if (r_state == ST_APPLY) begin
        for (int c = 0; c < COLS; c++) begin
          for (int r = 0; r < ROWS; r++) begin
            if (w_entryInRange && (int'(w_entryCol) == c) && (int'(w_entryRow) == r)) begin
              r_keys[c][r] <= r_evt[9];
            end
          end
        end
        if (w_isF11) begin
          r_swrstHeld <= r_evt[9];
          if (r_evt[9]) begin
            r_swrstCnt <= CW'(RST_PULSE);
          end
        end
        if (w_isF10) begin
          r_swnmi <= r_evt[9];
        end
      end
    end
  end

  always_comb begin
    w_rowNext = '1;
    for (int c = 0; c < COLS; c++) begin
      if (int'(i_col) == c) begin
        w_rowNext = ~r_keys[c];
      end
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_rowBit <= '1;
      r_anyKey <= 1'b0;
    end else begin
      r_rowBit <= w_rowNext;
      r_anyKey <= |r_keys;
    end
  end

  assign o_ROWbit  = r_rowBit;
  assign o_swrst   = r_swrstHeld || (r_swrstCnt != '0);
  assign o_swnmi   = r_swnmi;
  assign o_any_key = r_anyKey;
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_kbd_matrix_mapper.sv
// Bench for kbd_matrix_mapper: directed scenarios plus random key traffic.
// Results are compared against a behavioural keyboard model.
module tb_kbd_matrix_mapper;

  localparam int COLS       = 8;
  localparam int ROWS       = 8;
  localparam int COLW       = 3;
  localparam int ROWW       = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int RST_PULSE  = 16;
  localparam int MW         = 1 + COLW + ROWW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            keyStrobe = 1'b0;
  logic            keyPressed = 1'b0;
  logic            keyExtended = 1'b0;
  logic [7:0]      keyCode = '0;
  logic            mapWe = 1'b0;
  logic [8:0]      mapAddr = '0;
  logic [MW-1:0]   mapData = '0;
  logic            clearAll = 1'b0;
  logic [COLW-1:0] col = '0;
  logic [ROWS-1:0] rowBit;
  logic            swrst;
  logic            swnmi;
  logic            anyKey;
  logic            ovf;

  int              vectorCount = 0;
  int              missCount = 0;
  logic [ROWS-1:0] keyModel [COLS];
  logic [MW-1:0]   mapModel [512];
  logic [9:0]      pendQ [$];
  bit              modelOvf;
  bit              modelNmi;
  bit              modelRstHeld;

  always #5 clk = ~clk;

  kbd_matrix_mapper #(
    .COLS(COLS), .ROWS(ROWS), .COLW(COLW), .ROWW(ROWW),
    .FIFO_DEPTH(FIFO_DEPTH), .RST_PULSE(RST_PULSE)
  ) dut (
    .i_clk_sys(clk),
    .i_reset(reset),
    .i_key_strobe(keyStrobe),
    .i_key_pressed(keyPressed),
    .i_key_extended(keyExtended),
    .i_key_code(keyCode),
    .i_map_we(mapWe),
    .i_map_addr(mapAddr),
    .i_map_data(mapData),
    .i_clear_all(clearAll),
    .i_col(col),
    .o_ROWbit(rowBit),
    .o_swrst(swrst),
    .o_swnmi(swnmi),
    .o_any_key(anyKey),
    .o_ovf(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    for (int c = 0; c < COLS; c++) keyModel[c] = '0;
    modelNmi = 1'b0;
    modelRstHeld = 1'b0;
  endtask

  task automatic modelReset();
    modelClear();
    modelOvf = 1'b0;
    pendQ.delete();
  endtask

  // A key event as the keyboard sees it: the map picks the cell, hotkeys come from the raw code.
  task automatic modelApply(input logic [9:0] ev);
    logic [MW-1:0] entry;
    int ec;
    int er;
    entry = mapModel[ev[8:0]];
    ec = int'(entry[COLW+ROWW-1:ROWW]);
    er = int'(entry[ROWW-1:0]);
    if (entry[MW-1] && ec < COLS && er < ROWS) keyModel[ec][er] = ev[9];
    if (!ev[8] && ev[7:0] == 8'h78) modelRstHeld = ev[9];
    if (!ev[8] && ev[7:0] == 8'h09) modelNmi = ev[9];
  endtask

  task automatic modelPush(input logic [9:0] ev);
    if (pendQ.size() < FIFO_DEPTH) pendQ.push_back(ev);
    else modelOvf = 1'b1;
  endtask

  task automatic modelDrain();
    while (pendQ.size() > 0) modelApply(pendQ.pop_front());
  endtask

  task automatic writeMap(input logic [8:0] addr, input logic [MW-1:0] data);
    mapWe = 1'b1;
    mapAddr = addr;
    mapData = data;
    tick();
    mapWe = 1'b0;
    mapModel[addr] = data;
  endtask

  task automatic applyStimulus(input logic pressed, input logic [8:0] addr);
    keyStrobe = 1'b1;
    keyPressed = pressed;
    keyExtended = addr[8];
    keyCode = addr[7:0];
    tick();
    keyStrobe = 1'b0;
    modelPush({pressed, addr});
  endtask

  task automatic pressKey(input logic pressed, input logic [8:0] addr);
    applyStimulus(pressed, addr);
    repeat (8) tick();
    modelDrain();
  endtask

  task automatic checkAll(input string tag);
    logic [ROWS-1:0] expRow;
    bit anyExp;
    anyExp = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      col = COLW'(c);
      tick();
      expRow = ~keyModel[c];
      checkOutput($sformatf("%s rowbit col%0d", tag, c), rowBit, expRow);
      if (keyModel[c] != '0) anyExp = 1'b1;
    end
    checkOutput({tag, " any_key"}, anyKey, anyExp);
    checkOutput({tag, " swnmi"}, swnmi, modelNmi);
    checkOutput({tag, " swrst"}, swrst, modelRstHeld);
    checkOutput({tag, " ovf"}, ovf, modelOvf);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int highCount;
    bit seen;
    logic [ROWS-1:0] expRow;
    logic [8:0] rAddr [10];
    logic [8:0] addr;

    modelReset();
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("reset rowbit", rowBit, 8'hFF);
    checkOutput("reset swrst", swrst, 1'b0);
    checkOutput("reset ovf", ovf, 1'b0);
    for (int a = 0; a < 512; a++) writeMap(9'(a), '0);
    checkAll("after reset");

    $display("[TB] single key press/release with latency bound");
    writeMap(9'h01C, {1'b1, 3'd6, 3'd5});
    col = 3'd6;
    tick();
    applyStimulus(1'b1, 9'h01C);
    modelDrain();
    expRow = ~keyModel[6];
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (rowBit == expRow) seen = 1'b1;
    end
    checkOutput("press latency", seen, 1'b1);
    checkAll("press 1C");
    pressKey(1'b0, 9'h01C);
    checkAll("release 1C");

    $display("[TB] two keys in one column, extended and invalid entries");
    writeMap(9'h059, {1'b1, 3'd7, 3'd4});
    writeMap(9'h055, {1'b1, 3'd7, 3'd7});
    writeMap(9'h175, {1'b1, 3'd4, 3'd3});
    pressKey(1'b1, 9'h059);
    pressKey(1'b1, 9'h055);
    pressKey(1'b1, 9'h175);
    pressKey(1'b1, 9'h075);
    pressKey(1'b1, 9'h059);
    checkAll("multi");

    $display("[TB] NMI hotkey");
    pressKey(1'b1, 9'h009);
    checkAll("f10 make");
    pressKey(1'b0, 9'h009);
    checkAll("f10 break");

    $display("[TB] reset hotkey pulse stretch");
    applyStimulus(1'b1, 9'h078);
    tick();
    applyStimulus(1'b0, 9'h078);
    checkOutput("swrst before apply", swrst, 1'b0);
    highCount = 0;
    repeat (40) begin
      tick();
      if (swrst) highCount++;
    end
    checkOutput("swrst pulse width", highCount, RST_PULSE);
    modelDrain();
    checkAll("after f11");

    $display("[TB] clear_all colliding with APPLY");
    applyStimulus(1'b1, 9'h01C);
    tick();
    tick();
    clearAll = 1'b1;
    tick();
    clearAll = 1'b0;
    void'(pendQ.pop_front());
    modelClear();
    repeat (6) tick();
    checkAll("clear collide");

    $display("[TB] map write during LOOKUP");
    applyStimulus(1'b1, 9'h01C);
    tick();
    mapWe = 1'b1;
    mapAddr = 9'h01C;
    mapData = {1'b1, 3'd2, 3'd1};
    tick();
    mapWe = 1'b0;
    mapModel[9'h01C] = {1'b1, 3'd2, 3'd1};
    repeat (8) tick();
    modelDrain();
    checkAll("remap lookup");

    $display("[TB] event FIFO overflow");
    clearAll = 1'b1;
    tick();
    clearAll = 1'b0;
    modelClear();
    for (int i = 0; i < 7; i++) writeMap(9'(16 + i), {1'b1, COLW'(i), ROWW'((i * 3) % 8)});
    mapWe = 1'b1;
    mapAddr = 9'h1FF;
    mapData = '0;
    mapModel[9'h1FF] = '0;
    applyStimulus(1'b1, 9'h010);
    modelApply(pendQ.pop_front());
    for (int i = 1; i < 7; i++) applyStimulus(1'b1, 9'(16 + i));
    mapWe = 1'b0;
    repeat (30) tick();
    modelDrain();
    checkAll("overflow");

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    modelReset();
    checkOutput("post-reset ovf", ovf, 1'b0);
    checkOutput("post-reset rowbit", rowBit, 8'hFF);
    checkAll("post-reset");

    $display("[TB] random traffic");
    for (int i = 0; i < 10; i++) begin
      rAddr[i] = 9'($urandom_range(160, 511));
      writeMap(rAddr[i], MW'($urandom));
    end
    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom_range(0, 10);
      addr = (k == 10) ? 9'h009 : rAddr[k];
      if ($urandom_range(0, 7) == 0) begin
        clearAll = 1'b1;
        tick();
        clearAll = 1'b0;
        modelClear();
      end
      pressKey(1'($urandom_range(0, 1)), addr);
      checkAll($sformatf("random %0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
